// File: rtl/chime_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chime_sequencer: beat-timed hourly chime / alarm melody with tone output   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module chime_sequencer #(
    parameter int BEAT_CYC  = 50000000,
    parameter int ON_BEATS  = 1,
    parameter int OFF_BEATS = 1,
    parameter int TONE_W    = 20,
    parameter int STRIKE_HP = 113636
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic [1:0] mode,
    input  logic [5:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       alarm_en,
    input  logic [5:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_stop,
    output logic       speak,
    output logic       busy,
    output logic [3:0] strikes_left
);
    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_STRIKE_ON  = 2'd1;
    localparam logic [1:0] c_STRIKE_OFF = 2'd2;
    localparam logic [1:0] c_MELODY     = 2'd3;

    localparam int c_BC_W   = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
    localparam int c_MAXB_A = (ON_BEATS > OFF_BEATS) ? ON_BEATS : OFF_BEATS;
    localparam int c_MAXB   = (c_MAXB_A > 8) ? c_MAXB_A : 8;
    localparam int c_BI_W   = $clog2(c_MAXB);

    localparam logic [c_BC_W-1:0] c_BEAT_LAST = c_BC_W'(BEAT_CYC - 1);
    localparam logic [c_BC_W-1:0] c_BC_ONE    = c_BC_W'(1);
    localparam logic [c_BI_W-1:0] c_ON_LAST   = c_BI_W'(ON_BEATS - 1);
    localparam logic [c_BI_W-1:0] c_OFF_LAST  = c_BI_W'(OFF_BEATS - 1);
    localparam logic [c_BI_W-1:0] c_NOTE_LAST = c_BI_W'(7);
    localparam logic [c_BI_W-1:0] c_BI_ONE    = c_BI_W'(1);
    localparam logic [TONE_W-1:0] c_T_ONE     = TONE_W'(1);

    function automatic logic [TONE_W-1:0] melody_hp(input logic [2:0] idx);
        case (idx)
            3'd0:    melody_hp = TONE_W'(191131);
            3'd1:    melody_hp = TONE_W'(170300);
            3'd2:    melody_hp = TONE_W'(151700);
            3'd3:    melody_hp = TONE_W'(143184);
            3'd4:    melody_hp = TONE_W'(113636);
            3'd5:    melody_hp = TONE_W'(0);
            default: melody_hp = TONE_W'(191131);
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [c_BC_W-1:0] beat_q, beat_d;
    logic [c_BI_W-1:0] bidx_q, bidx_d;
    logic [3:0]        strikes_q, strikes_d;
    logic              chime_m_q, alarm_m_q;
    logic              busy_q, busy_d;
    logic [TONE_W-1:0] hp_q, hp_d;
    logic [TONE_W-1:0] tcnt_q;
    logic              speak_q;

    logic       w_chime_m, w_alarm_m, w_chime_rise, w_alarm_rise, w_beat_end;
    logic [3:0] w_h12, w_strike_n;

    assign w_chime_m = on && (mode != 2'd0) && (sec == 6'd0) &&
                       ((min == 6'd0) || ((mode == 2'd3) && (min == 6'd30))) &&
                       (hour < 6'd24);
    assign w_alarm_m = on && alarm_en && (hour == alarm_hour) &&
                       (min == alarm_min) && (sec == 6'd0);
    assign w_chime_rise = w_chime_m && !chime_m_q;
    assign w_alarm_rise = w_alarm_m && !alarm_m_q;
    assign w_beat_end   = (beat_q == c_BEAT_LAST);

    // 12-hour dial: hour 0 and 12 both strike twelve
    assign w_h12      = (hour >= 6'd12) ? 4'(hour - 6'd12) : 4'(hour);
    assign w_strike_n = ((min == 6'd30) || (mode == 2'd1)) ? 4'd1 :
                        ((w_h12 == 4'd0) ? 4'd12 : w_h12);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_IDLE;
            beat_q    <= '0;
            bidx_q    <= '0;
            strikes_q <= '0;
            chime_m_q <= 1'b0;
            alarm_m_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            bidx_q    <= bidx_d;
            strikes_q <= strikes_d;
            chime_m_q <= w_chime_m;
            alarm_m_q <= w_alarm_m;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        strikes_d = strikes_q;
        beat_d    = w_beat_end ? '0 : (beat_q + c_BC_ONE);
        bidx_d    = w_beat_end ? (bidx_q + c_BI_ONE) : bidx_q;
        case (state_q)
            c_IDLE: begin
                beat_d = '0;
                bidx_d = '0;
                if (w_alarm_rise) begin
                    state_d = c_MELODY;
                end else if (w_chime_rise) begin
                    state_d   = c_STRIKE_ON;
                    strikes_d = w_strike_n;
                end
            end
            c_STRIKE_ON, c_STRIKE_OFF: begin
                if (w_alarm_rise) begin
                    state_d   = c_MELODY;
                    strikes_d = 4'd0;
                    beat_d    = '0;
                    bidx_d    = '0;
                end else if (state_q == c_STRIKE_ON) begin
                    if (w_beat_end && (bidx_q == c_ON_LAST)) begin
                        state_d = c_STRIKE_OFF;
                        bidx_d  = '0;
                    end
                end else if (w_beat_end && (bidx_q == c_OFF_LAST)) begin
                    strikes_d = strikes_q - 4'd1;
                    state_d   = (strikes_q == 4'd1) ? c_IDLE : c_STRIKE_ON;
                    bidx_d    = '0;
                end
            end
            default: begin
                if (alarm_stop || (w_beat_end && (bidx_q == c_NOTE_LAST))) begin
                    state_d = c_IDLE;
                    beat_d  = '0;
                    bidx_d  = '0;
                end
            end
        endcase
        if (!on) begin
            state_d   = c_IDLE;
            strikes_d = 4'd0;
            beat_d    = '0;
            bidx_d    = '0;
        end
    end

    // Tone selection follows the next state so a segment's first toggle lands hp cycles after entry
    always_comb begin
        case (state_d)
            c_STRIKE_ON: hp_d = TONE_W'(STRIKE_HP);
            c_MELODY:    hp_d = melody_hp(bidx_d[2:0]);
            default:     hp_d = '0;
        endcase
        busy_d = (state_d != c_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q    <= '0;
            tcnt_q  <= '0;
            speak_q <= 1'b0;
        end else if (hp_d != hp_q) begin
            hp_q    <= hp_d;
            tcnt_q  <= '0;
            speak_q <= 1'b0;
        end else if (hp_q == '0) begin
            tcnt_q  <= '0;
            speak_q <= 1'b0;
        end else if (tcnt_q == (hp_q - c_T_ONE)) begin
            tcnt_q  <= '0;
            speak_q <= ~speak_q;
        end else begin
            tcnt_q  <= tcnt_q + c_T_ONE;
        end
    end

    assign speak        = speak_q;
    assign busy         = busy_q;
    assign strikes_left = strikes_q;

endmodule
`default_nettype wire

// File: tb/tb_chime_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_chime_sequencer: directed and random stimulus against a segment model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_chime_sequencer;
    localparam int BEAT_CYC  = 8;
    localparam int ON_BEATS  = 1;
    localparam int OFF_BEATS = 1;
    localparam int STRIKE_HP = 3;

    logic       clk = 1'b0;
    logic       rst, on, alarm_en, alarm_stop;
    logic [1:0] mode;
    logic [5:0] hour, min, sec, alarm_hour, alarm_min;
    logic       speak, busy;
    logic [3:0] strikes_left;

    int errors = 0;
    int checks = 0;

    chime_sequencer #(
        .BEAT_CYC (BEAT_CYC),
        .ON_BEATS (ON_BEATS),
        .OFF_BEATS(OFF_BEATS),
        .TONE_W   (20),
        .STRIKE_HP(STRIKE_HP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .on          (on),
        .mode        (mode),
        .hour        (hour),
        .min         (min),
        .sec         (sec),
        .alarm_en    (alarm_en),
        .alarm_hour  (alarm_hour),
        .alarm_min   (alarm_min),
        .alarm_stop  (alarm_stop),
        .speak       (speak),
        .busy        (busy),
        .strikes_left(strikes_left)
    );

    always #5 clk = ~clk;

    // Reference: a queue of timed tone segments still to be played
    int q_hp[$];
    int q_len[$];
    int q_sl[$];
    bit q_mel[$];
    int mel_rom[8] = '{191131, 170300, 151700, 143184, 113636, 0, 191131, 191131};
    bit c_prev, a_prev;
    int prev_hp, t_run;
    int exp_speak, exp_busy, exp_sl;

    function automatic void model_reset();
        q_hp.delete(); q_len.delete(); q_sl.delete(); q_mel.delete();
        c_prev = 0; a_prev = 0; prev_hp = 0; t_run = 0;
        exp_speak = 0; exp_busy = 0; exp_sl = 0;
    endfunction

    function automatic void push_seg(int hp, int len, int sl, bit mel);
        q_hp.push_back(hp); q_len.push_back(len); q_sl.push_back(sl); q_mel.push_back(mel);
    endfunction

    function automatic void clear_segs();
        q_hp.delete(); q_len.delete(); q_sl.delete(); q_mel.delete();
    endfunction

    function automatic int strikes_for(int h, int mn, int md);
        if (mn == 30 || md == 1) return 1;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    function automatic void model_edge();
        bit cm, am, cr, ar, playing;
        int hp;
        if (rst) begin
            model_reset();
            return;
        end
        cm = on && mode != 0 && sec == 0 && (min == 0 || (mode == 3 && min == 30)) && hour < 24;
        am = on && alarm_en && hour == alarm_hour && min == alarm_min && sec == 0;
        cr = cm && !c_prev;
        ar = am && !a_prev;
        c_prev = cm;
        a_prev = am;
        playing = q_hp.size() > 0;
        if (!on) begin
            clear_segs();
        end else if (playing && q_mel[0] && alarm_stop) begin
            clear_segs();
        end else if (ar && !(playing && q_mel[0])) begin
            clear_segs();
            for (int i = 0; i < 8; i++) push_seg(mel_rom[i], BEAT_CYC, 0, 1'b1);
        end else if (cr && !playing) begin
            for (int k = strikes_for(hour, min, mode); k >= 1; k--) begin
                push_seg(STRIKE_HP, ON_BEATS * BEAT_CYC, k, 1'b0);
                push_seg(0, OFF_BEATS * BEAT_CYC, k, 1'b0);
            end
        end else if (playing) begin
            q_len[0] = q_len[0] - 1;
            if (q_len[0] == 0) begin
                void'(q_hp.pop_front()); void'(q_len.pop_front());
                void'(q_sl.pop_front()); void'(q_mel.pop_front());
            end
        end
        hp = (q_hp.size() > 0) ? q_hp[0] : 0;
        if (hp != prev_hp) t_run = 0;
        else t_run++;
        prev_hp   = hp;
        exp_speak = (hp == 0) ? 0 : ((t_run / hp) % 2);
        exp_busy  = (q_hp.size() > 0) ? 1 : 0;
        exp_sl    = (q_hp.size() > 0) ? q_sl[0] : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input int expv);
        checks++;
        assert (got === expv)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic check_outputs();
        check("speak", {31'd0, speak}, exp_speak);
        check("busy", {31'd0, busy}, exp_busy);
        check("strikes_left", {28'd0, strikes_left}, exp_sl);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour = 6'(h); min = 6'(m); sec = 6'(s);
    endtask

    // Reset asserted between clock edges must clear outputs without a clock
    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        ticks(2);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; on = 1'b1; mode = 2'd2; alarm_en = 1'b0; alarm_stop = 1'b0;
        alarm_hour = 6'd0; alarm_min = 6'd0;
        set_time(15, 59, 0);
        model_reset();
        #2;
        check_outputs();
        ticks(2);
        rst = 1'b0;
        ticks(3);

        // Three strikes at 15:00, trigger level held for 40 cycles
        set_time(15, 0, 0);
        ticks(40);
        sec = 6'd1;
        ticks(20);

        // Twelve strikes at midnight and noon, single strike mode, invalid hour
        set_time(0, 0, 0);   ticks(200);
        set_time(12, 59, 1); ticks(2);
        set_time(12, 0, 0);  ticks(200);
        mode = 2'd1;
        set_time(7, 0, 1);   ticks(2);
        set_time(7, 0, 0);   ticks(20);
        set_time(25, 0, 1);  ticks(2);
        set_time(25, 0, 0);  ticks(20);

        // Half-hour strike only in mode 3
        mode = 2'd3;
        set_time(9, 30, 0);  ticks(20);
        mode = 2'd2;
        set_time(9, 30, 1);  ticks(2);
        set_time(9, 30, 0);  ticks(20);

        // Alarm preempts the second strike of a five-strike chime
        alarm_hour = 6'd5; alarm_min = 6'd0;
        set_time(5, 59, 0);  ticks(2);
        set_time(5, 0, 0);   ticks(20);
        alarm_en = 1'b1;     ticks(70);

        // alarm_stop during note 3, then a fresh alarm restarts the melody
        alarm_en = 1'b0;     ticks(2);
        alarm_en = 1'b1;     ticks(26);
        alarm_stop = 1'b1;   tick();
        alarm_stop = 1'b0;   ticks(3);
        alarm_en = 1'b0;     tick();
        alarm_en = 1'b1;     ticks(70);
        alarm_en = 1'b0;
        sec = 6'd1;          ticks(3);

        // Asynchronous reset mid-strike
        set_time(4, 0, 0);   ticks(4);
        async_reset();
        ticks(70);
        sec = 6'd1;          ticks(2);

        // on dropped mid-strike, then restored with the trigger still present
        set_time(6, 0, 0);   ticks(20);
        on = 1'b0;           ticks(5);
        on = 1'b1;           ticks(110);
        sec = 6'd1;          ticks(2);

        // Trigger present across reset release
        set_time(3, 0, 0);
        async_reset();
        ticks(60);
        sec = 6'd1;          ticks(2);

        // Random traffic
        for (int k = 0; k < 200; k++) begin
            int r;
            mode = 2'($urandom_range(0, 3));
            hour = 6'($urandom_range(0, 25));
            r = $urandom_range(0, 3);
            min  = (r == 0) ? 6'd0 : (r == 1) ? 6'd30 : (r == 2) ? 6'd59 : 6'($urandom_range(0, 59));
            sec  = ($urandom_range(0, 2) == 0) ? 6'd1 : 6'd0;
            on   = ($urandom_range(0, 15) != 0);
            alarm_en   = 1'($urandom_range(0, 1));
            alarm_hour = ($urandom_range(0, 1) == 1) ? hour : 6'($urandom_range(0, 23));
            alarm_min  = ($urandom_range(0, 1) == 1) ? min : 6'($urandom_range(0, 59));
            alarm_stop = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 40) == 0) async_reset();
            ticks($urandom_range(1, 25));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
